instruction_memory_loader: RTL and testbench

Byte-serial program loader, the write side of the instruction memory that the processor fetch path reads.
- Accepts a framed byte stream: a word-count header followed by little-endian 32-bit instruction words.
- Writes each assembled word into instruction memory at consecutive word addresses.
- Holds the processor core in reset until the whole program is written, replacing file preload for hardware bring-up.

---
 rtl/instruction_memory_loader_pkg.sv | 18 +
 rtl/instruction_memory_loader_if.sv | 25 ++
 rtl/instruction_memory_loader_word_assembler.sv | 36 +++
 rtl/instruction_memory_loader.sv | 100 ++++++++++
 tb/tb_instruction_memory_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the byte-serial instruction memory loader.
package instruction_memory_loader_pkg;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      WRITE,
      DONE,
      LOADED,
      ERR
   } loader_state_t;

   localparam int INSTR_WIDTH    = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int HEADER_BYTES   = 2;

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_memory_loader_if #(
   parameter int ADDR_WIDTH = 64
);
   import instruction_memory_loader_pkg::*;

   logic [7:0]             byte_in;
   logic                   byte_valid;
   logic                   byte_ready;
   logic                   mem_write_enable;
   logic [ADDR_WIDTH-1:0]  mem_address;
   logic [INSTR_WIDTH-1:0] mem_write_data;

   // Master is the byte source; it also observes the memory write side.
   modport master (
      output byte_in, byte_valid,
      input  byte_ready, mem_write_enable, mem_address, mem_write_data
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, mem_write_enable, mem_address, mem_write_data
   );

endinterface

// File: rtl/instruction_memory_loader_word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit instruction word.
module loader_word_assembler
   import instruction_memory_loader_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   accept,
   input  logic [7:0]             byte_in,
   output logic [INSTR_WIDTH-1:0] word_next,
   output logic                   word_complete
);

   logic [1:0]             byte_index;
   logic [INSTR_WIDTH-1:0] word;

   // Word as it will look once the current byte lands; lets the top register
   // the complete word on the same edge the 4th byte is accepted.
   always_comb begin
      word_next = word;
      word_next[8*byte_index +: 8] = byte_in;
   end

   assign word_complete = accept && (byte_index == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         byte_index <= '0;
         word       <= '0;
      end else if (accept) begin
         word       <= word_next;
         byte_index <= byte_index + 2'd1;
      end
   end

endmodule

// File: rtl/instruction_memory_loader.sv
// Framed byte-stream program loader: writes N words to instruction memory and
// holds the CPU in reset until the whole program has been written.
module instruction_memory_loader
   import instruction_memory_loader_pkg::*;
#(
   parameter int                    ADDR_WIDTH      = 64,
   parameter int                    MEM_DEPTH_WORDS = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS    = '0
) (
   input  logic                        clock,
   input  logic                        reset,
   instruction_memory_loader_if.slave  bus,
   output logic                        cpu_hold,
   output logic                        load_done,
   output logic                        load_error
);

   loader_state_t          state;
   logic [15:0]            word_count;
   logic [15:0]            word_index;
   logic [15:0]            header_count;
   logic                   fire;
   logic [INSTR_WIDTH-1:0] word_next;
   logic                   word_complete;

   assign fire         = bus.byte_valid && bus.byte_ready;
   assign header_count = {bus.byte_in, word_count[7:0]};

   loader_word_assembler u_assembler (
      .clock         (clock),
      .reset         (reset),
      .clear         (state != DATA),
      .accept        (fire && (state == DATA)),
      .byte_in       (bus.byte_in),
      .word_next     (word_next),
      .word_complete (word_complete)
   );

   // NOTE: every output is a flop updated with <= so all of them change on the
   // same edge as the state; blocking assignments here would race the readers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state                <= HDR_LO;
         word_count           <= '0;
         word_index           <= '0;
         bus.byte_ready       <= 1'b1;
         bus.mem_write_enable <= 1'b0;
         bus.mem_address      <= BASE_ADDRESS;
         bus.mem_write_data   <= '0;
         cpu_hold             <= 1'b1;
         load_done            <= 1'b0;
         load_error           <= 1'b0;
      end else begin
         bus.mem_write_enable <= 1'b0;
         load_done            <= 1'b0;
         case (state)
            HDR_LO: if (fire) begin
               word_count[7:0] <= bus.byte_in;
               state           <= HDR_HI;
            end
            HDR_HI: if (fire) begin
               word_count <= header_count;
               if (header_count == 16'd0) begin
                  state          <= DONE;
                  load_done      <= 1'b1;
                  cpu_hold       <= 1'b0;
                  bus.byte_ready <= 1'b0;
               end else if (header_count > 16'(MEM_DEPTH_WORDS)) begin
                  state      <= ERR;
                  load_error <= 1'b1;
               end else begin
                  state <= DATA;
               end
            end
            DATA: if (word_complete) begin
               bus.mem_write_enable <= 1'b1;
               bus.mem_write_data   <= word_next;
               bus.mem_address      <= BASE_ADDRESS + (ADDR_WIDTH'(word_index) << 2);
               word_index           <= word_index + 16'd1;
               bus.byte_ready       <= 1'b0;
               state                <= WRITE;
            end
            // word_index already counts the word written this cycle.
            WRITE: if (word_index == word_count) begin
               state     <= DONE;
               load_done <= 1'b1;
               cpu_hold  <= 1'b0;
            end else begin
               bus.byte_ready <= 1'b1;
               state          <= DATA;
            end
            DONE:    state <= LOADED;
            LOADED:  state <= LOADED;
            ERR:     state <= ERR;
            default: state <= HDR_LO;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed, table-driven bench for instruction_memory_loader.
module tb_instruction_memory_loader;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] n;
      int          gap;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        expect_error;
   } frame_vec_t;

   logic clock;
   logic reset;
   logic cpu_hold;
   logic load_done;
   logic load_error;

   int  vectors;
   int  miscompares;
   wr_t writes[$];
   int  done_count;
   int  ready_low_bad;

   instruction_memory_loader_if #(.ADDR_WIDTH(64)) ifc ();

   instruction_memory_loader #(
      .ADDR_WIDTH      (64),
      .MEM_DEPTH_WORDS (64),
      .BASE_ADDRESS    (64'd0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (ifc.slave),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Passive monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (ifc.mem_write_enable === 1'b1)
         writes.push_back('{addr: ifc.mem_address, data: ifc.mem_write_data});
      if (load_done === 1'b1)
         done_count++;
      if (reset === 1'b1 && ifc.byte_ready === 1'b0 && ifc.mem_write_enable !== 1'b1
          && cpu_hold === 1'b1)
         ready_low_bad++;
   end

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic apply_reset(input logic valid_during);
      @(negedge clock);
      reset          = 1'b0;
      ifc.byte_valid = valid_during;
      ifc.byte_in    = 8'hFF;
      writes.delete();
      done_count     = 0;
      ready_low_bad  = 0;
      repeat (2) @(negedge clock);
      reset          = 1'b1;
      ifc.byte_valid = 1'b0;
   endtask

   // Returns #1 after the edge on which the byte transferred.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      waited = 0;
      repeat (gap) @(negedge clock);
      @(negedge clock);
      ifc.byte_in    = b;
      ifc.byte_valid = 1'b1;
      while (ifc.byte_ready !== 1'b1 && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      if (ifc.byte_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL send_byte_timeout: byte_ready=%b after %0d cycles, expected 1", ifc.byte_ready, waited);
         @(negedge clock);
      end else begin
         @(posedge clock);
      end
      #1;
      ifc.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int b = 0; b < 4; b++)
         send_byte(w[8*b +: 8], gap);
   endtask

   function automatic logic [31:0] big_word(input int i);
      logic [7:0] lo;
      lo = 8'(i);
      return {lo, 8'h96, ~lo, 8'h3C};
   endfunction

   frame_vec_t vecs[5];

   initial begin
      int ready_high;
      int bad_data;
      logic [31:0] w;

      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      ifc.byte_in    = 8'h00;
      ifc.byte_valid = 1'b0;

      vecs[0] = '{n: 16'd2,  gap: 0, w0: 32'hCB120210, w1: 32'hB40000D0, expect_error: 1'b0};
      vecs[1] = '{n: 16'd2,  gap: 3, w0: 32'hCB120210, w1: 32'hB40000D0, expect_error: 1'b0};
      vecs[2] = '{n: 16'd0,  gap: 0, w0: 32'h0,        w1: 32'h0,        expect_error: 1'b0};
      vecs[3] = '{n: 16'd65, gap: 0, w0: 32'h0,        w1: 32'h0,        expect_error: 1'b1};
      vecs[4] = '{n: 16'd1,  gap: 1, w0: 32'hDEADBEEF, w1: 32'h0,        expect_error: 1'b0};

      // Reset held two cycles with byte_valid asserted.
      apply_reset(1'b1);
      check("rst_byte_ready", 64'(ifc.byte_ready), 64'd1);
      check("rst_cpu_hold",   64'(cpu_hold),       64'd1);
      check("rst_load_error", 64'(load_error),     64'd0);
      check("rst_load_done",  64'(load_done),      64'd0);
      check("rst_we",         64'(ifc.mem_write_enable), 64'd0);
      check("rst_addr",       ifc.mem_address,     64'd0);
      check("rst_wdata",      64'(ifc.mem_write_data), 64'd0);
      check("rst_no_writes",  64'(writes.size()),  64'd0);

      for (int i = 0; i < 5; i++) begin
         apply_reset(1'b0);
         send_byte(vecs[i].n[7:0], vecs[i].gap);
         send_byte(vecs[i].n[15:8], vecs[i].gap);
         if (vecs[i].expect_error) begin
            repeat (3) send_byte(8'h5A, vecs[i].gap);
            repeat (3) @(negedge clock);
            check($sformatf("v%0d_load_error", i), 64'(load_error), 64'd1);
            check($sformatf("v%0d_cpu_hold", i),   64'(cpu_hold),   64'd1);
            check($sformatf("v%0d_ready", i),      64'(ifc.byte_ready), 64'd1);
            check($sformatf("v%0d_writes", i),     64'(writes.size()), 64'd0);
            check($sformatf("v%0d_done", i),       64'(done_count), 64'd0);
         end else begin
            for (int k = 0; k < int'(vecs[i].n); k++) begin
               w = (k == 0) ? vecs[i].w0 : vecs[i].w1;
               send_word(w, vecs[i].gap);
               check($sformatf("v%0d_w%0d_strobe_latency", i, k), 64'(ifc.mem_write_enable), 64'd1);
            end
            if (vecs[i].n != 16'd0) begin
               @(posedge clock);
               #1;
            end
            check($sformatf("v%0d_load_done_timing", i), 64'(load_done), 64'd1);
            check($sformatf("v%0d_cpu_hold_drop", i),    64'(cpu_hold),  64'd0);
            repeat (3) @(negedge clock);
            check($sformatf("v%0d_write_count", i), 64'(writes.size()), 64'(vecs[i].n));
            for (int k = 0; k < int'(vecs[i].n) && k < writes.size(); k++) begin
               w = (k == 0) ? vecs[i].w0 : vecs[i].w1;
               check($sformatf("v%0d_w%0d_addr", i, k), writes[k].addr, 64'(4 * k));
               check($sformatf("v%0d_w%0d_data", i, k), 64'(writes[k].data), 64'(w));
            end
            check($sformatf("v%0d_done_pulses", i), 64'(done_count), 64'd1);
            check($sformatf("v%0d_ready_low_outside_write", i), 64'(ready_low_bad), 64'd0);
         end
      end

      // Full-capacity frame: N = 64.
      apply_reset(1'b0);
      send_byte(8'd64, 0);
      send_byte(8'd0, 0);
      for (int k = 0; k < 64; k++)
         send_word(big_word(k), 0);
      repeat (4) @(negedge clock);
      check("n64_write_count", 64'(writes.size()), 64'd64);
      bad_data = 0;
      for (int k = 0; k < writes.size(); k++)
         if (writes[k].data !== big_word(k) || writes[k].addr !== 64'(4 * k))
            bad_data++;
      check("n64_bad_writes", 64'(bad_data), 64'd0);
      if (writes.size() > 0)
         check("n64_last_addr", writes[writes.size()-1].addr, 64'd252);
      check("n64_done_pulses", 64'(done_count), 64'd1);
      check("n64_cpu_hold", 64'(cpu_hold), 64'd0);
      check("n64_load_error", 64'(load_error), 64'd0);

      // Reset after five data bytes, then a fresh one-word frame.
      apply_reset(1'b0);
      send_byte(8'd2, 0);
      send_byte(8'd0, 0);
      send_word(32'h44332211, 0);
      send_byte(8'h55, 0);
      apply_reset(1'b0);
      send_byte(8'd1, 0);
      send_byte(8'd0, 0);
      send_word(32'h0BADF00D, 0);
      repeat (4) @(negedge clock);
      check("midrst_write_count", 64'(writes.size()), 64'd1);
      if (writes.size() > 0) begin
         check("midrst_addr", writes[0].addr, 64'd0);
         check("midrst_data", 64'(writes[0].data), 64'h0BADF00D);
      end
      check("midrst_done_pulses", 64'(done_count), 64'd1);

      // Bytes presented after the load completed are refused.
      ready_high = 0;
      @(negedge clock);
      ifc.byte_in    = 8'hA7;
      ifc.byte_valid = 1'b1;
      repeat (8) begin
         @(negedge clock);
         if (ifc.byte_ready !== 1'b0) ready_high++;
      end
      ifc.byte_valid = 1'b0;
      check("loaded_ready_high_cycles", 64'(ready_high), 64'd0);
      check("loaded_write_count", 64'(writes.size()), 64'd1);
      check("loaded_cpu_hold", 64'(cpu_hold), 64'd0);
      check("loaded_done_pulses", 64'(done_count), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
